output_mode_sequencer: RTL and testbench

Parametrised mode sequencer that turns a raw, asynchronous mode selector (switches) into registered one-hot output-path enables (PWM, R2R and buzzer paths) for the waveform generators.
- Synchronises the selector to clk.
- Qualifies a new selection only after it has been stable for a set number of cycles.
- Enforces break-before-make dead time (all enables low) between modes.
- Sits between the board switch inputs and the waveform/output-path mux.

---
 rtl/output_mode_pkg.sv | 24 ++
 rtl/output_mode_sequencer_sync_2ff.sv | 24 ++
 rtl/output_mode_sequencer.sv | 119 +++++++++++
 tb/tb_output_mode_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/output_mode_pkg.sv
// Shared types and constants for the output mode sequencer.
package output_mode_pkg;

  // Sequencer states: steady, waiting for a stable new request, break-before-make gap.
  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_DEAD    = 2'd2
  } state_t;

  // Board mode indices as wired to the output-path mux.
  localparam int MODE_OFF     = 0;
  localparam int TRIANGLE_PWM = 1;
  localparam int TRIANGLE_R2R = 2;
  localparam int TONE_BUZZER  = 3;
  localparam int EXTRA        = 4;
  localparam int SAW_PWM      = 5;
  localparam int SAW_R2R      = 6;
  localparam int CHIRP_BUZZER = 7;

  // Modes 0 and 4 drive no output path; every other mode drives its own enable bit.
  localparam logic [31:0] DEFAULT_VALID_MASK = 32'h0000_00EE;

endpackage

// File: rtl/output_mode_sequencer_sync_2ff.sv
// Two-flop bus synchroniser for the slowly changing switch inputs.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two register stages; q is usable two edges after d settles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/output_mode_sequencer.sv
// Turns a raw switch mode selector into registered one-hot output-path enables,
// with a stability qualifier and break-before-make dead time between modes.
module output_mode_sequencer
  import output_mode_pkg::*;
#(
  parameter int                    NUM_MODES     = 8,
  parameter int                    SEL_W         = $clog2(NUM_MODES),
  parameter int                    STABLE_CYCLES = 16,
  parameter int                    DEAD_CYCLES   = 4,
  parameter logic [NUM_MODES-1:0]  VALID_MASK    = DEFAULT_VALID_MASK[NUM_MODES-1:0]
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [SEL_W-1:0]     mode_select,
  output logic [NUM_MODES-1:0] enable_onehot,
  output logic [SEL_W-1:0]     active_mode,
  output logic                 switching,
  output logic                 mode_change_pulse,
  output logic [1:0]           state_dbg
);

  localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
  localparam int DCNT_W = $clog2(DEAD_CYCLES + 1);

  state_t             state;
  logic [SEL_W-1:0]   sync_raw;
  logic [SEL_W-1:0]   sync_sel;
  logic [SEL_W-1:0]   cand;
  logic [CNT_W-1:0]   cnt;
  logic [DCNT_W-1:0]  dcnt;

  sync_2ff #(.WIDTH(SEL_W)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (mode_select),
    .q       (sync_raw)
  );

  // Out-of-range selector codes behave exactly like the off mode 0.
  assign sync_sel  = (32'(sync_raw) >= 32'(NUM_MODES)) ? '0 : sync_raw;
  assign state_dbg = state;

  // Enable pattern for a committed mode; masked modes drive nothing.
  function automatic logic [NUM_MODES-1:0] mode_enable(input logic [SEL_W-1:0] m);
    logic [NUM_MODES-1:0] e;
    e = '0;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (int'(m) == i) e[i] = VALID_MASK[i];
    end
    return e;
  endfunction

  // Sequencer FSM; every output is registered alongside state so enables never overlap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= ST_ACTIVE;
      active_mode       <= '0;
      cand              <= '0;
      cnt               <= '0;
      dcnt              <= '0;
      enable_onehot     <= '0;
      switching         <= 1'b0;
      mode_change_pulse <= 1'b0;
    end else begin
      mode_change_pulse <= 1'b0;
      case (state)
        ST_ACTIVE: begin
          if (sync_sel != active_mode) begin
            cand      <= sync_sel;
            switching <= 1'b1;
            if (STABLE_CYCLES == 1) begin
              state         <= ST_DEAD;
              dcnt          <= '0;
              enable_onehot <= '0;
            end else begin
              state <= ST_QUALIFY;
              cnt   <= CNT_W'(1);
            end
          end
        end
        ST_QUALIFY: begin
          if (sync_sel == active_mode) begin
            // Request withdrawn: stay on the current mode without any gap.
            state     <= ST_ACTIVE;
            switching <= 1'b0;
            cnt       <= '0;
          end else if (sync_sel != cand) begin
            cand <= sync_sel;
            cnt  <= CNT_W'(1);
          end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
            state         <= ST_DEAD;
            dcnt          <= '0;
            cnt           <= '0;
            enable_onehot <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DEAD: begin
          if (dcnt == DCNT_W'(DEAD_CYCLES - 1)) begin
            state             <= ST_ACTIVE;
            active_mode       <= cand;
            enable_onehot     <= mode_enable(cand);
            switching         <= 1'b0;
            mode_change_pulse <= 1'b1;
            dcnt              <= '0;
          end else begin
            dcnt <= dcnt + DCNT_W'(1);
          end
        end
        default: begin
          state     <= ST_ACTIVE;
          switching <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_mode_sequencer.sv
// Directed bench for output_mode_sequencer: default instance plus a 6-mode instance.
module tb_output_mode_sequencer;

  logic       clk;
  logic       reset_n;
  logic [2:0] sel;
  logic [7:0] en;
  logic [2:0] act;
  logic       sw;
  logic       pulse;
  logic [1:0] st;

  logic [2:0] sel6;
  logic [5:0] en6;
  logic [2:0] act6;
  logic       sw6;
  logic       pulse6;
  logic [1:0] st6;

  int total;
  int passed;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] exp_en;
    logic [2:0] exp_act;
  } vec_t;

  vec_t vecs[8];

  output_mode_sequencer dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .mode_select       (sel),
    .enable_onehot     (en),
    .active_mode       (act),
    .switching         (sw),
    .mode_change_pulse (pulse),
    .state_dbg         (st)
  );

  output_mode_sequencer #(.NUM_MODES(6), .SEL_W(3)) dut6 (
    .clk               (clk),
    .reset_n           (reset_n),
    .mode_select       (sel6),
    .enable_onehot     (en6),
    .active_mode       (act6),
    .switching         (sw6),
    .mode_change_pulse (pulse6),
    .state_dbg         (st6)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One active edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
  endtask

  initial begin
    int npulse;
    logic [7:0] e_en;

    total   = 0;
    passed  = 0;
    reset_n = 1'b0;
    sel     = 3'd0;
    sel6    = 3'd0;

    vecs[0] = '{3'd5, 8'h20, 3'd5};
    vecs[1] = '{3'd1, 8'h02, 3'd1};
    vecs[2] = '{3'd2, 8'h04, 3'd2};
    vecs[3] = '{3'd4, 8'h00, 3'd4};
    vecs[4] = '{3'd7, 8'h80, 3'd7};
    vecs[5] = '{3'd0, 8'h00, 3'd0};
    vecs[6] = '{3'd3, 8'h08, 3'd3};
    vecs[7] = '{3'd6, 8'h40, 3'd6};

    settle(3);
    chk("reset_en", 32'(en), 32'h0);
    chk("reset_state", 32'(st), 32'd0);
    reset_n = 1'b1;

    // 1: idle after reset
    for (int k = 0; k < 50; k++) begin
      step();
      chk("idle_en", 32'(en), 32'h0);
      chk("idle_act", 32'(act), 32'd0);
      chk("idle_sw", 32'(sw), 32'd0);
      chk("idle_pulse", 32'(pulse), 32'd0);
    end

    // 2: 0 -> 5 latency profile
    sel = 3'd5;
    for (int k = 1; k <= 24; k++) begin
      step();
      chk($sformatf("lat_en_e%0d", k), 32'(en), (k >= 22) ? 32'h20 : 32'h0);
      chk($sformatf("lat_sw_e%0d", k), 32'(sw), (k >= 3 && k <= 21) ? 32'd1 : 32'd0);
      chk($sformatf("lat_pulse_e%0d", k), 32'(pulse), (k == 22) ? 32'd1 : 32'd0);
      chk($sformatf("lat_act_e%0d", k), 32'(act), (k >= 22) ? 32'd5 : 32'd0);
      chk($sformatf("lat_state_e%0d", k), 32'(st),
          (k < 3) ? 32'd0 : (k < 18) ? 32'd1 : (k < 22) ? 32'd2 : 32'd0);
    end

    // 3: glitch to 3 for 10 cycles from mode 1 is aborted
    sel = 3'd1;
    settle(30);
    chk("pre3_en", 32'(en), 32'h02);
    sel = 3'd3;
    npulse = 0;
    for (int k = 0; k < 30; k++) begin
      if (k == 10) sel = 3'd1;
      step();
      chk("abort_en", 32'(en), 32'h02);
      if (pulse) npulse++;
    end
    chk("abort_pulses", 32'(npulse), 32'd0);
    chk("abort_sw", 32'(sw), 32'd0);
    chk("abort_act", 32'(act), 32'd1);

    // 4: 2 for 8 cycles then 6 restarts qualification
    sel = 3'd2;
    settle(8);
    sel = 3'd6;
    for (int k = 1; k <= 24; k++) begin
      step();
      e_en = (k < 18) ? 8'h02 : (k < 22) ? 8'h00 : 8'h40;
      chk($sformatf("restart_en_e%0d", k), 32'(en), 32'(e_en));
      chk($sformatf("restart_pulse_e%0d", k), 32'(pulse), (k == 22) ? 32'd1 : 32'd0);
    end

    // Table of full mode transitions, each held long enough to commit
    foreach (vecs[i]) begin
      sel = vecs[i].sel;
      npulse = 0;
      for (int k = 0; k < 30; k++) begin
        step();
        if (pulse) npulse++;
      end
      chk($sformatf("tbl%0d_en", i), 32'(en), 32'(vecs[i].exp_en));
      chk($sformatf("tbl%0d_act", i), 32'(act), 32'(vecs[i].exp_act));
      chk($sformatf("tbl%0d_sw", i), 32'(sw), 32'd0);
      chk($sformatf("tbl%0d_pulses", i), 32'(npulse), 32'd1);
    end

    // 5: six-mode instance, codes 6 and 7 alias mode 0
    sel6 = 3'd7;
    for (int k = 0; k < 30; k++) begin
      if (k == 15) sel6 = 3'd6;
      step();
      chk("range_sw", 32'(sw6), 32'd0);
      chk("range_pulse", 32'(pulse6), 32'd0);
      chk("range_state", 32'(st6), 32'd0);
    end
    chk("range_act", 32'(act6), 32'd0);
    sel6 = 3'd5;
    settle(30);
    chk("six_en5", 32'(en6), 32'h20);
    chk("six_act5", 32'(act6), 32'd5);
    sel6 = 3'd7;
    settle(30);
    chk("six_en7", 32'(en6), 32'h0);
    chk("six_act7", 32'(act6), 32'd0);

    // 6: reset during DEAD after a 1 -> 7 request
    sel = 3'd1;
    settle(30);
    chk("pre6_en", 32'(en), 32'h02);
    sel = 3'd7;
    settle(19);
    chk("pre6_state", 32'(st), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("async_en", 32'(en), 32'h0);
    chk("async_act", 32'(act), 32'd0);
    chk("async_sw", 32'(sw), 32'd0);
    chk("async_pulse", 32'(pulse), 32'd0);
    chk("async_state", 32'(st), 32'd0);
    settle(2);
    reset_n = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      chk($sformatf("post_act_e%0d", k), 32'(act), (k >= 22) ? 32'd7 : 32'd0);
      chk($sformatf("post_pulse_e%0d", k), 32'(pulse), (k == 22) ? 32'd1 : 32'd0);
    end
    chk("post_en", 32'(en), 32'h80);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
